// File: rtl/booth_ctrl.sv
// Sequencer for the radix-2 Booth multiplier datapath: drives cv = {dp_rst, add, sub, load, shift, dc}.
// Optional BOOTH_ITER_CHECK_EN adds a shadow iteration counter that cross-checks the datapath count flag.
module booth_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q1,
  input  logic       q0,
  input  logic       count,
  output logic [5:0] cv,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CVW   = 6;
  localparam int unsigned SW    = $clog2(N + 1);
  localparam int unsigned CV_RST = 5;
  localparam int unsigned CV_ADD = 4;
  localparam int unsigned CV_SUB = 3;
  localparam int unsigned CV_LD  = 2;
  localparam int unsigned CV_SH  = 1;
  localparam int unsigned CV_DC  = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_EVAL, S_SHIFT, S_CHECK, S_DONE
  } state_t;

  typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} op_t;

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [CVW-1:0] cv_d;
  logic           busy_d, done_d;
  logic           at_n;

  // Next state plus output decode of that next state, so every output is a register.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cv_d    = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLR;
      S_CLR:   state_d = S_LOAD;
      S_LOAD:  state_d = S_EVAL;
      S_EVAL: begin
        case ({q1, q0})
          2'b10:   op_d = OP_SUB;
          2'b01:   op_d = OP_ADD;
          default: op_d = OP_NOP;
        endcase
        state_d = S_SHIFT;
      end
      S_SHIFT: state_d = S_CHECK;
      S_CHECK: state_d = (count || at_n) ? S_DONE : S_EVAL;
      S_DONE:  state_d = start ? S_CLR : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_CLR: begin
        cv_d[CV_RST] = 1'b1;
        busy_d       = 1'b1;
      end
      S_LOAD: begin
        cv_d[CV_LD] = 1'b1;
        busy_d      = 1'b1;
      end
      S_SHIFT: begin
        cv_d[CV_SH]  = 1'b1;
        cv_d[CV_DC]  = 1'b1;
        cv_d[CV_ADD] = (op_d == OP_ADD);
        cv_d[CV_SUB] = (op_d == OP_SUB);
        busy_d       = 1'b1;
      end
      S_EVAL, S_CHECK: busy_d = 1'b1;
      S_DONE:          done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      cv      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cv      <= cv_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

`ifdef BOOTH_ITER_CHECK_EN
  logic [SW-1:0] shadow_q, shadow_d;
  logic          err_q, err_d;

  assign at_n = (shadow_q == SW'(N));

  // Shadow iteration count; err flags any disagreement with the datapath terminal flag.
  always_comb begin
    shadow_d = shadow_q;
    err_d    = err_q;
    if (state_d == S_CLR) begin
      shadow_d = '0;
      err_d    = 1'b0;
    end else if (state_q == S_SHIFT) begin
      shadow_d = shadow_q + SW'(1);
    end else if ((state_q == S_CHECK) && (count != at_n)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign at_n = 1'b0;
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_booth_ctrl.sv
// Self-checking bench for booth_ctrl with a behavioural Booth datapath and a scoreboard of
// expected products, done cycles and per-iteration add/sub ops.
module tb_booth_ctrl;

  localparam int unsigned N = 4;

  typedef struct packed {
    logic [7:0]  prod;
    int unsigned cyc;
  } exp_t;

  logic       clk, rst, start, q1, q0, count;
  logic [5:0] cv;
  logic       busy, done, err;

  // Datapath model state
  logic [3:0] min_v, qin_v, m, a, q;
  logic       qm1;
  logic [2:0] cnt;
  logic [4:0] sum;
  int unsigned cnt_mode;

  int unsigned cyc, last_launch, shift_cnt, at;
  int          total, bad;
  bit          sb_en;
  exp_t        exp_q[$];
  logic [1:0]  op_q[$];
  exp_t        e;
  logic [1:0]  eo;

  booth_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .q1    (q1),
    .q0    (q0),
    .count (count),
    .cv    (cv),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Booth datapath with a 5-bit adder so the most negative multiplicand does not overflow A.
  initial begin
    m = '0; a = '0; q = '0; qm1 = 1'b0; cnt = '0;
  end
  always @(posedge clk) begin
    if (cv[5]) begin
      a <= '0; qm1 <= 1'b0; cnt <= '0;
    end
    if (cv[2]) begin
      m <= min_v; q <= qin_v;
    end
    if (cv[1]) begin
      sum = {a[3], a};
      if (cv[4])      sum = sum + {m[3], m};
      else if (cv[3]) sum = sum - {m[3], m};
      a   <= sum[4:1];
      q   <= {sum[0], q[3:1]};
      qm1 <= q[0];
      cnt <= cnt + 3'd1;
    end
  end

  assign q1    = q[0];
  assign q0    = qm1;
  assign count = (cnt_mode == 1) ? 1'b1 : (cnt_mode == 2) ? 1'b0 : (cnt == 3'(N));

  // Scoreboard consumer: products/done timing on done, op pattern on each shift.
  always @(negedge clk) begin
    if (!rst && sb_en) begin
      if (done === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done at cyc %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({a, q} !== e.prod) begin
            bad++;
            $display("FAIL product got %h want %h", {a, q}, e.prod);
          end
          total++;
          if (cyc !== e.cyc) begin
            bad++;
            $display("FAIL done_cycle got %0d want %0d", cyc, e.cyc);
          end
        end
      end
      if (cv[1] === 1'b1) begin
        shift_cnt++;
        total++;
        if (op_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_shift at cyc %0d", cyc);
        end else begin
          eo = op_q.pop_front();
          if ({cv[4], cv[3], cv[0]} !== {eo, 1'b1}) begin
            bad++;
            $display("FAIL shift_op got add/sub/dc=%b want %b", {cv[4], cv[3], cv[0]}, {eo, 1'b1});
          end
        end
      end
    end
  end

  // Push expectations for an operation whose start is sampled at the next posedge.
  task automatic expect_op(input logic [3:0] mv, input logic [3:0] qv);
    logic [7:0] pr;
    logic       p;
    last_launch = cyc;
    if (sb_en) begin
      pr = {{4{mv[3]}}, mv} * {{4{qv[3]}}, qv};
      exp_q.push_back('{prod: pr, cyc: cyc + 15});
      p = 1'b0;
      for (int i = 0; i < 4; i++) begin
        case ({qv[i], p})
          2'b10:   op_q.push_back(2'b01);
          2'b01:   op_q.push_back(2'b10);
          default: op_q.push_back(2'b00);
        endcase
        p = qv[i];
      end
    end
  endtask

  task automatic launch(input logic [3:0] mv, input logic [3:0] qv);
    min_v = mv;
    qin_v = qv;
    expect_op(mv, qv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int unsigned when);
    bit found;
    found = 0;
    when  = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1;
        when  = cyc;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL done_timeout no done within 40 cycles");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({cv, busy, done, err} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs got %b want 0", {cv, busy, done, err});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({cv, busy, done} !== 8'b0) begin
      bad++;
      $display("FAIL idle_outputs got %b want 0", {cv, busy, done});
    end
  endtask

  task automatic test_basic;
    bit ok;
    launch(4'd3, 4'b1110);
    total++;
    if (cv !== 6'b100000) begin
      bad++;
      $display("FAIL clr_cv got %b want 100000", cv);
    end
    ok = 1;
    for (int k = 1; k <= 14; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) ok = 0;
      if (k < 14) @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL busy_window busy/done wrong within cycles 1-14");
    end
    @(negedge clk);
    total++;
    if ({busy, done, cv} !== 8'b01_000000) begin
      bad++;
      $display("FAIL done_cycle15 got %b want 01000000", {busy, done, cv});
    end
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL after_done got %b want 00", {busy, done});
    end
  endtask

  task automatic test_op_decode;
    launch(4'b0111, 4'b0101);
    wait_done(at);
    @(negedge clk);
    launch(4'b1000, 4'b1000);
    wait_done(at);
    @(negedge clk);
  endtask

  task automatic test_nop;
    shift_cnt = 0;
    launch(4'd5, 4'b0000);
    wait_done(at);
    total++;
    if (shift_cnt !== 4) begin
      bad++;
      $display("FAIL nop_shift_count got %0d want 4", shift_cnt);
    end
    total++;
    if (at !== last_launch + 15) begin
      bad++;
      $display("FAIL nop_done_cycle got %0d want %0d", at - last_launch, 15);
    end
    @(negedge clk);
  endtask

  task automatic test_start_held;
    bit ok;
    min_v = 4'd2;
    qin_v = 4'd3;
    expect_op(4'd2, 4'd3);
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_done(at);
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) ok = 0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL start_held busy reasserted after single operation");
    end
  endtask

  task automatic test_back_to_back;
    int unsigned first;
    launch(4'b1101, 4'b0110);
    wait_done(first);
    launch(4'b0100, 4'b1011);
    total++;
    if ({cv, busy, done} !== 8'b100000_1_0) begin
      bad++;
      $display("FAIL b2b_clr got %b want 10000010", {cv, busy, done});
    end
    wait_done(at);
    total++;
    if (at !== first + 15) begin
      bad++;
      $display("FAIL b2b_spacing got %0d want 15", at - first);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    launch(4'd7, 4'd7);
    repeat (6) @(negedge clk);
    total++;
    if (cv[1] !== 1'b1) begin
      bad++;
      $display("FAIL midop_in_shift got cv %b want shift set", cv);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({cv, busy, done} !== 8'b0) begin
      bad++;
      $display("FAIL async_reset got %b want 0", {cv, busy, done});
    end
    exp_q.delete();
    op_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({cv, busy} !== 7'b0) begin
      bad++;
      $display("FAIL post_reset_idle got %b want 0", {cv, busy});
    end
    launch(4'b0110, 4'b1101);
    wait_done(at);
    @(negedge clk);
  endtask

`ifdef BOOTH_ITER_CHECK_EN
  task automatic test_iter_check;
    sb_en    = 0;
    cnt_mode = 1;
    launch(4'd3, 4'd3);
    wait_done(at);
    total++;
    if (at !== last_launch + 6 || err !== 1'b1) begin
      bad++;
      $display("FAIL early_count got cycle %0d err %b want 6 and 1", at - last_launch, err);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got %b want 1", err);
    end
    cnt_mode = 2;
    launch(4'd3, 4'd3);
    wait_done(at);
    total++;
    if (at !== last_launch + 15 || err !== 1'b1) begin
      bad++;
      $display("FAIL missing_count got cycle %0d err %b want 15 and 1", at - last_launch, err);
    end
    @(negedge clk);
    cnt_mode = 0;
    sb_en    = 1;
    launch(4'd5, 4'b1011);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got %b want 0", err);
    end
    wait_done(at);
    @(negedge clk);
  endtask
`else
  task automatic test_iter_check;
    cnt_mode = 2;
    repeat (5) @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_tied got %b want 0", err);
    end
    cnt_mode = 0;
  endtask
`endif

  initial begin
    total    = 0;
    bad      = 0;
    sb_en    = 1;
    cnt_mode = 0;
    start    = 1'b0;
    min_v    = '0;
    qin_v    = '0;
    rst      = 1'b1;
    test_reset();
    test_basic();
    test_op_decode();
    test_nop();
    test_start_held();
    test_back_to_back();
    test_reset_midop();
    test_iter_check();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || op_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations got %0d/%0d want 0/0", exp_q.size(), op_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
